// File: rtl/and_demux_unit.sv
// Registered primitive-gate stage: WIDTH-bit vector AND, scalar AND and a 1-to-2 demux.
// Latency: exactly one clock from the sampling edge; no combinational input-to-output path.
// Backpressure: none; en gates capture, and valid pulses for one cycle per enabled capture.
//
// Ports:
//   clk            system clock, all state updates on the rising edge
//   rst            synchronous active-high reset, takes priority over en
//   en             capture enable, inputs are sampled only when high
//   a16, b16       vector AND operands (WIDTH bits)
//   a, b           scalar AND operands
//   in, sel        demux data and select (sel=0 routes to dmux_a, sel=1 to dmux_b)
//   out16          registered a16 & b16
//   out_and        registered a & b
//   dmux_a, dmux_b registered demux outputs, never both high
//   valid          one-cycle pulse after each enabled capture
module and_demux_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] a16,
  input  logic [WIDTH-1:0] b16,
  input  logic             a,
  input  logic             b,
  input  logic             in,
  input  logic             sel,
  output logic [WIDTH-1:0] out16,
  output logic             out_and,
  output logic             dmux_a,
  output logic             dmux_b,
  output logic             valid
);

  logic [WIDTH-1:0] r_out16;
  logic             r_out_and;
  logic             r_dmux_a;
  logic             r_dmux_b;
  logic             r_valid;

  // Next-state values computed from the inputs present at the edge.
  logic [WIDTH-1:0] w_and16;
  logic             w_and1;
  logic             w_dmux_a;
  logic             w_dmux_b;

  assign w_and16  = a16 & b16;
  assign w_and1   = a & b;
  // Both demux legs are qualified by in, so they are both 0 when in=0
  // and mutually exclusive otherwise.
  assign w_dmux_a = in & ~sel;
  assign w_dmux_b = in &  sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out16   <= '0;
      r_out_and <= 1'b0;
      r_dmux_a  <= 1'b0;
      r_dmux_b  <= 1'b0;
      r_valid   <= 1'b0;
    end else if (en) begin
      r_out16   <= w_and16;
      r_out_and <= w_and1;
      r_dmux_a  <= w_dmux_a;
      r_dmux_b  <= w_dmux_b;
      r_valid   <= 1'b1;
    end else begin
      // Data holds its last captured value; only valid drops.
      r_valid   <= 1'b0;
    end
  end

  assign out16   = r_out16;
  assign out_and = r_out_and;
  assign dmux_a  = r_dmux_a;
  assign dmux_b  = r_dmux_b;
  assign valid   = r_valid;

endmodule

// File: tb/tb_and_demux_unit.sv
module tb_and_demux_unit;

  localparam int WIDTH = 16;
  localparam int EW    = WIDTH + 4;

  logic             clk;
  logic             rst;
  logic             en;
  logic [WIDTH-1:0] a16;
  logic [WIDTH-1:0] b16;
  logic             a;
  logic             b;
  logic             in;
  logic             sel;
  logic [WIDTH-1:0] out16;
  logic             out_and;
  logic             dmux_a;
  logic             dmux_b;
  logic             valid;

  int n_cmp  = 0;
  int n_fail = 0;

  // Expected post-edge output vector: {out16, out_and, dmux_a, dmux_b, valid}.
  logic [EW-1:0] exp_q[$];
  string         name_q[$];

  and_demux_unit #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .en(en),
    .a16(a16), .b16(b16), .a(a), .b(b), .in(in), .sel(sel),
    .out16(out16), .out_and(out_and), .dmux_a(dmux_a), .dmux_b(dmux_b),
    .valid(valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one edge's worth of inputs (at negedge) and queue the hand-computed
  // outputs expected after the following rising edge.
  task automatic step(input string nm,
                      input logic r, input logic e,
                      input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                      input logic sa, input logic sb, input logic di, input logic ds,
                      input logic [WIDTH-1:0] x16, input logic xand,
                      input logic xda, input logic xdb, input logic xv);
    @(negedge clk);
    rst = r; en = e; a16 = va; b16 = vb; a = sa; b = sb; in = di; sel = ds;
    exp_q.push_back({x16, xand, xda, xdb, xv});
    name_q.push_back(nm);
  endtask

  // Monitor: after each rising edge, pop one expectation and compare.
  initial begin
    logic [EW-1:0] got;
    logic [EW-1:0] exp;
    string         nm;
    forever begin
      @(posedge clk);
      #1;
      got = {out16, out_and, dmux_a, dmux_b, valid};
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        nm  = name_q.pop_front();
        n_cmp++;
        if (got !== exp) begin
          n_fail++;
          $display("FAIL %s: got out16=%h and=%b da=%b db=%b v=%b, want out16=%h and=%b da=%b db=%b v=%b",
                   nm, got[EW-1:4], got[3], got[2], got[1], got[0],
                   exp[EW-1:4], exp[3], exp[2], exp[1], exp[0]);
        end
        n_cmp++;
        if (dmux_a === 1'b1 && dmux_b === 1'b1) begin
          n_fail++;
          $display("FAIL %s demux_exclusive: got da=%b db=%b, want not both 1", nm, dmux_a, dmux_b);
        end
      end else if (valid === 1'b1) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_valid: got valid=%b with no pending stimulus, want 0", valid);
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b1; a16 = '1; b16 = '1; a = 1'b1; b = 1'b1; in = 1'b1; sel = 1'b1;

    // Reset held for two edges with all inputs high, then release.
    step("rst0",   1, 1, 16'hFFFF, 16'hFFFF, 1, 1, 1, 1, 16'h0000, 0, 0, 0, 0);
    step("rst1",   1, 1, 16'hFFFF, 16'hFFFF, 1, 1, 1, 1, 16'h0000, 0, 0, 0, 0);
    step("rst_rel",0, 1, 16'hFFFF, 16'hFFFF, 1, 1, 1, 0, 16'hFFFF, 1, 1, 0, 1);

    // Scalar AND truth table.
    step("and00",  0, 1, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 1);
    step("and01",  0, 1, 16'h0000, 16'h0000, 0, 1, 0, 0, 16'h0000, 0, 0, 0, 1);
    step("and10",  0, 1, 16'h0000, 16'h0000, 1, 0, 0, 0, 16'h0000, 0, 0, 0, 1);
    step("and11",  0, 1, 16'h0000, 16'h0000, 1, 1, 0, 0, 16'h0000, 1, 0, 0, 1);

    // Vector AND.
    step("vec_f0", 0, 1, 16'hF0F0, 16'hFF00, 0, 0, 0, 0, 16'hF000, 0, 0, 0, 1);
    step("vec_aa", 0, 1, 16'hAAAA, 16'h5555, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 1);
    step("vec_12", 0, 1, 16'h1234, 16'h1234, 0, 0, 0, 0, 16'h1234, 0, 0, 0, 1);

    // Demux sweep {in,sel}.
    step("dmx00",  0, 1, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 1);
    step("dmx01",  0, 1, 16'h0000, 16'h0000, 0, 0, 0, 1, 16'h0000, 0, 0, 0, 1);
    step("dmx10",  0, 1, 16'h0000, 16'h0000, 0, 0, 1, 0, 16'h0000, 0, 1, 0, 1);
    step("dmx11",  0, 1, 16'h0000, 16'h0000, 0, 0, 1, 1, 16'h0000, 0, 0, 1, 1);

    // Hold: capture out_and=1 and dmux_b=1, then drop en for 3 cycles.
    step("hold_cap",0, 1, 16'h00C3, 16'h00FF, 1, 1, 1, 1, 16'h00C3, 1, 0, 1, 1);
    step("hold1",  0, 0, 16'hFFFF, 16'h0000, 0, 1, 0, 0, 16'h00C3, 1, 0, 1, 0);
    step("hold2",  0, 0, 16'hFFFF, 16'h0000, 0, 1, 1, 0, 16'h00C3, 1, 0, 1, 0);
    step("hold3",  0, 0, 16'hFFFF, 16'h0000, 0, 1, 0, 1, 16'h00C3, 1, 0, 1, 0);
    step("reen",   0, 1, 16'h0000, 16'h0000, 0, 1, 0, 0, 16'h0000, 0, 0, 0, 1);

    // Reset mid-stream.
    step("mid_pre",0, 1, 16'hFFFF, 16'h00FF, 0, 0, 0, 0, 16'h00FF, 0, 0, 0, 1);
    step("mid_rst",1, 1, 16'hFFFF, 16'h00FF, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0);
    step("mid_rel",0, 1, 16'hFFFF, 16'h00FF, 0, 0, 0, 0, 16'h00FF, 0, 0, 0, 1);

    // Reset with en low, then idle cycle: valid must stay low.
    step("rst_en0",1, 0, 16'hFFFF, 16'hFFFF, 1, 1, 1, 0, 16'h0000, 0, 0, 0, 0);
    step("idle",   0, 0, 16'hFFFF, 16'hFFFF, 1, 1, 1, 0, 16'h0000, 0, 0, 0, 0);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no completion by 100000, want completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/and_demux_unit.md
Name: and_demux_unit

Overview:
- Registered bundle of three basic logic functions: 16-bit bitwise AND, 1-bit AND, and 1-to-2 demultiplexor.
- All results are captured on one clock edge, with 1-cycle latency and a shared valid flag.
- Used as a primitive-gate stage in the logic-gate library, feeding downstream mux/ALU blocks that expect registered, reset-clean inputs.

Parameters:
- WIDTH, 16, bit width of the vector AND path (a16, b16, out16); must be >= 1.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  capture enable; inputs sampled only when high.
- a16  input  WIDTH  vector AND operand A.
- b16  input  WIDTH  vector AND operand B.
- a  input  1  scalar AND operand A.
- b  input  1  scalar AND operand B.
- in  input  1  demultiplexor data input.
- sel  input  1  demultiplexor select.
- out16  output  WIDTH  registered a16 & b16.
- out_and  output  1  registered a & b.
- dmux_a  output  1  registered demux output A (selected when sel=0).
- dmux_b  output  1  registered demux output B (selected when sel=1).
- valid  output  1  high for one cycle after each enabled capture.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset: rst high at a rising edge forces out16=0, out_and=0, dmux_a=0, dmux_b=0, valid=0 on that edge.
  - rst has priority over en.
  - Outputs stay 0 while rst is held.
- Capture: at a rising edge with rst=0 and en=1, all outputs update together:
  - out16 <= a16 & b16, bitwise across all WIDTH bits.
  - out_and <= a & b.
  - dmux_a <= in when sel=0, else 0.
  - dmux_b <= in when sel=1, else 0.
  - valid <= 1.
- Hold: at a rising edge with rst=0 and en=0, out16, out_and, dmux_a and dmux_b hold their values; valid <= 0.
- Latency is exactly 1 cycle from the sampling edge. There is no combinational path from any input to any output.
- Demux invariant: dmux_a and dmux_b are never both 1. Both are 0 when in=0, regardless of sel.
- All inputs are sampled on the same edge; no skew between paths. Simultaneous changes of sel and in resolve to the values present at the edge.
- Reset mid-stream: asserting rst between enabled captures clears outputs and valid on that edge. The first enabled edge after rst deasserts produces fresh results with valid=1.
- X-free after the first reset edge: outputs are defined only by reset and captured inputs.
- Width rule: out16 has exactly WIDTH bits; no extension or truncation.

Test Plan:
- Reset: drive rst=1 for 2 cycles with en=1, a16=16'hFFFF, b16=16'hFFFF, a=b=in=1 -> all outputs 0 and valid=0 during and after the reset edges; first edge after release gives out16=16'hFFFF, out_and=1, valid=1.
- Scalar AND truth table: en=1, {a,b} stepped 00,01,10,11 on successive edges -> out_and = 0,0,0,1, each appearing one cycle after the inputs are applied.
- Vector AND: a16=16'hF0F0, b16=16'hFF00 -> out16=16'hF000. Then a16=16'hAAAA, b16=16'h5555 -> out16=16'h0000. Then a16=b16=16'h1234 -> out16=16'h1234.
- Demux sweep: {in,sel} = 00, 01, 10, 11 -> {dmux_a,dmux_b} = 00, 00, 10, 01; never 11.
- Hold: capture a=b=1 (out_and=1), then drop en and set a=0 for 3 cycles -> out_and stays 1 and valid=0 for those 3 cycles. Re-raise en -> out_and=0 and valid=1 next edge.
- Reset mid-operation: with en=1 streaming a16=16'hFFFF, b16=16'h00FF, assert rst for 1 cycle -> out16=0 and valid=0 on that edge; next edge gives out16=16'h00FF and valid=1.
